keccak_readout_seq: RTL and testbench
=====================================

# keccak_readout_seq

Sequencer that drains a 512-bit Keccak digest to the 32-bit processor side one word at a time. It captures the digest when the core signals completion, then steps a word index through the requested number of words, presenting each on a valid/ready port. It sits between the Keccak core output and keccak_ctrl, replacing direct index-driven word selection with a self-timed stream.

## Interface
- WORDS, 16, number of 32-bit words in the captured digest (512/32); index width is 4.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- digest_valid  input  1  one-cycle pulse: digest is final
- digest  input  512  Keccak output; word k = digest[32k+31:32k]
- len  input  4  words to send, sampled with digest_valid; 0 means 16
- abort  input  1  synchronous cancel of the current readout
- word_ready  input  1  consumer accepts word_data this cycle
- word_valid  output  1  word_data/word_idx are valid
- word_data  output  32  current word
- word_idx  output  4  index k of current word
- busy  output  1  high while in STREAM
- done  output  1  one-cycle pulse after the final word is accepted
- overrun  output  1  sticky: digest_valid arrived while busy
- clr_overrun  input  1  clears overrun

## Operation
- States: IDLE, STREAM.
- IDLE: word_valid=0, busy=0. On digest_valid (and no abort), latch digest into a 512-bit buffer, latch count = (len==0 ? 16 : len), set idx=0, go to STREAM.
- STREAM: word_valid=1, word_data=buf[32*idx+31:32*idx], word_idx=idx, busy=1.
  - Handshake = word_valid & word_ready. On handshake with idx < count-1: idx increments.
  - On handshake with idx == count-1: go to IDLE, pulse done next cycle.
  - word_data and word_idx hold stable while word_valid=1 and word_ready=0.
- abort in any state: next state IDLE, idx=0, no done. Abort wins over a simultaneous handshake and over a simultaneous digest_valid. The digest is dropped and overrun is not set.
- digest_valid while in STREAM (not aborting): ignored, buffer unchanged, overrun set to 1.
- overrun clears on clr_overrun. A simultaneous set and clear leaves it set.
- The index never wraps: the maximum count of 16 ends at idx=15.
- The buffer is not cleared on return to IDLE. Only reset clears it.

## Timing
- Reset values: state IDLE, idx=0, buffer=0, count=16. Outputs: word_valid=0, word_data=0, word_idx=0, busy=0, done=0, overrun=0.
- digest_valid sampled at edge n: word_valid=1 with word 0 from cycle n+1. Capture latency is one cycle.
- With word_ready held high, one word transfers per cycle. A len=N readout occupies cycles n+1..n+N.
- done is high for exactly one cycle, the cycle after the final handshake. In that cycle the state is already IDLE, busy=0 and word_valid=0.
- A digest_valid in the done cycle is accepted: back-to-back digests have one idle cycle between streams.
- abort at edge m: word_valid=0 and busy=0 from cycle m+1.
- word_data is a registered mux output and updates on the same edge as idx. There is no combinational path from word_ready to word_data.

## Test plan
- Full stream: digest with word k = 0xA5000000+k, len=0, word_ready=1. Expect 16 handshakes with idx 0..15 and data 0xA5000000..0xA500000F, busy for 16 cycles, done one cycle after idx 15, then IDLE.
- Partial, backpressured: len=8, word_ready toggles 1,0,0,1,... Expect exactly 8 words in order. word_data/word_idx stable during stalls. done after word 7. Words 8..15 never presented.
- Overrun: second digest_valid (different data) during word 3 of a stream. Expect the stream to continue with the original data, overrun=1 until clr_overrun, then 0.
- Abort: abort at idx=5 together with word_ready=1 and digest_valid=1. Expect word_valid=0 next cycle, no done, overrun=0. A following digest restarts at idx 0.
- Back-to-back: digest_valid in the done cycle of a previous len=1 readout. Expect the new word 0 on the next cycle with new data.
- Async reset: assert rst mid-stream (idx=9) between clock edges. All outputs go to reset values immediately, and the block stays IDLE after release until digest_valid.

Source files
------------

// File: rtl/keccak_readout_seq.sv
// Drains a captured 512-bit Keccak digest as a stream of 32-bit words on a valid/ready port.
// Captures on digest_valid, steps a word index through the requested count, then pulses done.
module keccak_readout_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         digest_valid,
    input  logic [511:0] digest,
    input  logic [3:0]   len,
    input  logic         abort,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [31:0]  word_data,
    output logic [3:0]   word_idx,
    output logic         busy,
    output logic         done,
    output logic         overrun,
    input  logic         clr_overrun
);

    localparam int unsigned WORDS  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DIG_W  = WORDS * WORD_W;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state, state_n;
    logic [DIG_W-1:0]   dbuf, dbuf_n;
    logic [IDX_W-1:0]   idx_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [WORD_W-1:0]  data_n;
    logic               done_n;
    logic               ovr_n;
    logic               ovr_set;
    logic               hs;
    logic               last;

    assign hs   = word_valid & word_ready;
    assign last = (word_idx == IDX_W'(count - CNT_W'(1)));

    // Next-state, capture, index stepping and overrun tracking
    always_comb begin
        state_n = state;
        dbuf_n  = dbuf;
        idx_n   = word_idx;
        count_n = count;
        done_n  = 1'b0;
        ovr_set = 1'b0;

        unique case (state)
            IDLE: begin
                if (abort) begin
                    idx_n = '0;
                end else if (digest_valid) begin
                    dbuf_n  = digest;
                    count_n = (len == '0) ? CNT_W'(WORDS) : CNT_W'(len);
                    idx_n   = '0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    idx_n   = '0;
                    state_n = IDLE;
                end else begin
                    ovr_set = digest_valid;
                    if (hs) begin
                        if (last) begin
                            idx_n   = '0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            idx_n = word_idx + IDX_W'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // set wins over a simultaneous clear
        ovr_n  = ovr_set | (overrun & ~clr_overrun);
        data_n = dbuf_n[{idx_n, 5'd0} +: WORD_W];
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dbuf       <= '0;
            count      <= CNT_W'(WORDS);
            word_idx   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            dbuf       <= dbuf_n;
            count      <= count_n;
            word_idx   <= idx_n;
            word_data  <= data_n;
            word_valid <= (state_n == STREAM);
            busy       <= (state_n == STREAM);
            done       <= done_n;
            overrun    <= ovr_n;
        end
    end

endmodule

// File: tb/tb_keccak_readout_seq.sv
// Self-checking bench for keccak_readout_seq: directed scenarios plus randomized traffic
// compared every cycle against a word-list model of the readout.
module tb_keccak_readout_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         digest_valid;
    logic [511:0] digest;
    logic [3:0]   len;
    logic         abort;
    logic         word_ready;
    logic         word_valid;
    logic [31:0]  word_data;
    logic [3:0]   word_idx;
    logic         busy;
    logic         done;
    logic         overrun;
    logic         clr_overrun;

    int vectors = 0;
    int errors  = 0;

    // Model: list of captured words, number to send, position, flags
    logic [31:0] m_words [16];
    int          m_count;
    int          m_pos;
    bit          m_active;
    bit          m_done;
    bit          m_ovr;

    keccak_readout_seq dut (
        .clk(clk), .rst(rst), .digest_valid(digest_valid), .digest(digest), .len(len),
        .abort(abort), .word_ready(word_ready), .word_valid(word_valid), .word_data(word_data),
        .word_idx(word_idx), .busy(busy), .done(done), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_words[k] = '0;
        m_count  = 16;
        m_pos    = 0;
        m_active = 0;
        m_done   = 0;
        m_ovr    = 0;
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit set_ovr;
        bit hs;
        set_ovr = 0;
        hs      = m_active && word_ready;
        m_done  = 0;
        if (abort) begin
            m_active = 0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (digest_valid) begin
                for (int k = 0; k < 16; k++) m_words[k] = digest[32*k +: 32];
                m_count  = (len == 0) ? 16 : int'(len);
                m_pos    = 0;
                m_active = 1;
            end
        end else begin
            set_ovr = digest_valid;
            if (hs) begin
                if (m_pos == m_count - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_pos++;
                end
            end
        end
        m_ovr = set_ovr || (m_ovr && !clr_overrun);
    endtask

    task automatic compare_all();
        check("word_valid", 32'(word_valid), 32'(m_active));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_active) begin
            check("word_idx", 32'(word_idx), 32'(m_pos));
            check("word_data", word_data, m_words[m_pos]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        digest_valid = 0;
        abort        = 0;
        word_ready   = 0;
        clr_overrun  = 0;
    endtask

    task automatic make_digest(input logic [31:0] base);
        for (int k = 0; k < 16; k++) digest[32*k +: 32] = base + 32'(k);
    endtask

    task automatic start(input logic [31:0] base, input logic [3:0] l);
        make_digest(base);
        len          = l;
        digest_valid = 1;
        step();
        digest_valid = 0;
    endtask

    initial begin
        int hs_count;
        int last_idx;
        logic [31:0] hold_data;
        logic [3:0]  hold_idx;

        idle_inputs();
        digest = '0;
        len    = '0;
        rst    = 1;
        model_reset();
        #12;
        compare_all();
        check("reset word_data", word_data, 32'h0);
        check("reset word_idx", 32'(word_idx), 32'h0);
        @(negedge clk);
        rst = 0;
        step();

        // Full stream, len=0 means 16
        word_ready = 1;
        start(32'hA500_0000, 4'd0);
        check("full first word", word_data, 32'hA500_0000);
        hs_count = 0;
        for (int c = 0; c < 20 && m_active; c++) begin
            if (word_valid) begin
                check("full literal data", word_data, 32'hA500_0000 + 32'(word_idx));
                hs_count++;
            end
            step();
        end
        check("full handshakes", 32'(hs_count), 32'd16);
        check("full done pulse", 32'(done), 32'd1);
        step();
        check("full done one cycle", 32'(done), 32'd0);

        // Partial with backpressure 1,0,0,1,0,0,...
        word_ready = 0;
        start(32'h1234_0000, 4'd8);
        hs_count = 0;
        last_idx = -1;
        for (int c = 0; c < 40 && m_active; c++) begin
            word_ready = (c % 3 == 0);
            if (word_valid && word_ready) begin
                check("partial order", 32'(word_idx), 32'(last_idx + 1));
                last_idx = int'(word_idx);
                hs_count++;
            end
            hold_data = word_data;
            hold_idx  = word_idx;
            step();
            if (!word_ready && word_valid) begin
                check("stall data stable", word_data, hold_data);
                check("stall idx stable", 32'(word_idx), 32'(hold_idx));
            end
        end
        check("partial count", 32'(hs_count), 32'd8);
        check("partial done", 32'(done), 32'd1);
        word_ready = 0;
        step();

        // Overrun: second digest during word 3
        word_ready = 1;
        start(32'hC000_0000, 4'd6);
        for (int c = 0; c < 10 && m_pos != 3; c++) step();
        make_digest(32'hDEAD_0000);
        digest_valid = 1;
        step();
        digest_valid = 0;
        check("overrun set", 32'(overrun), 32'd1);
        check("overrun keeps data", word_data, 32'hC000_0004);
        for (int c = 0; c < 10 && m_active; c++) step();
        step();
        check("overrun sticky", 32'(overrun), 32'd1);
        clr_overrun = 1;
        step();
        clr_overrun = 0;
        check("overrun cleared", 32'(overrun), 32'd0);

        // Abort at idx 5 with handshake and digest_valid together
        start(32'h5500_0000, 4'd0);
        for (int c = 0; c < 10 && m_pos != 5; c++) step();
        abort        = 1;
        digest_valid = 1;
        make_digest(32'h6600_0000);
        step();
        abort        = 0;
        digest_valid = 0;
        check("abort valid", 32'(word_valid), 32'd0);
        check("abort no done", 32'(done), 32'd0);
        check("abort no overrun", 32'(overrun), 32'd0);
        step();
        start(32'h7700_0000, 4'd2);
        check("restart idx", 32'(word_idx), 32'd0);
        check("restart data", word_data, 32'h7700_0000);
        for (int c = 0; c < 5 && m_active; c++) step();
        step();

        // Back-to-back: digest in the done cycle of a len=1 readout
        start(32'h0100_0000, 4'd1);
        step();
        check("b2b done", 32'(done), 32'd1);
        start(32'h0200_0000, 4'd1);
        check("b2b new data", word_data, 32'h0200_0000);
        check("b2b valid", 32'(word_valid), 32'd1);
        step();
        step();

        // Async reset mid-stream at idx 9
        start(32'h0900_0000, 4'd0);
        for (int c = 0; c < 15 && m_pos != 9; c++) step();
        #2;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        check("async word_data", word_data, 32'h0);
        check("async word_idx", 32'(word_idx), 32'h0);
        @(negedge clk);
        rst = 0;
        word_ready = 1;
        for (int c = 0; c < 4; c++) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            digest_valid = ($urandom_range(7) == 0);
            abort        = ($urandom_range(40) == 0);
            word_ready   = $urandom_range(1) == 1;
            clr_overrun  = ($urandom_range(15) == 0);
            len          = 4'($urandom_range(15));
            for (int k = 0; k < 16; k++) digest[32*k +: 32] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
